parallel_pe_pipe: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle parallel PE.

---
 rtl/parallel_pe_pipe.sv | 140 ++++++++++++++
 tb/tb_parallel_pe_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_pe_pipe.sv
// parallel_pe_pipe: pipelined LANES-wide signed dot product with group
// accumulation, optional saturation and a sticky per-group overflow flag.
//
// Handshake: an input beat transfers on a rising edge where vld_i & rdy_o;
// a result transfers on a rising edge where vld_o & rdy_i. Once vld_o is high,
// result/ovf_o are held stable until they transfer. rdy_o = adv, where
// adv = !vld_o | rdy_i; when adv is low the whole pipeline freezes.
//
// Pipeline: stage 1 registers lane products, stage 2 registers their sum,
// stage 3 folds the sum into the partial sum and emits on the last beat.
module parallel_pe_pipe #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic                  rdy_o,
  input  logic                  sat_en,
  output logic [ACC_W-1:0]      result,
  output logic                  ovf_o,
  output logic                  vld_o,
  input  logic                  rdy_i
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);
  localparam int W  = ((ACC_W > SW) ? ACC_W : SW) + 1;

  logic [PW-1:0]    prod_q [LANES];
  logic [PW-1:0]    prod_d [LANES];
  logic             v1_q, v1_d;
  logic [1:0]       ctl1_q, ctl1_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             v2_q, v2_d;
  logic [1:0]       ctl2_q, ctl2_d;
  logic [ACC_W-1:0] psum_q, psum_d;
  logic             ovf_grp_q, ovf_grp_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             vld_o_q, vld_o_d;

  logic             adv;
  logic [W-1:0]     base_w;
  logic [W-1:0]     nxt;
  logic             oor;
  logic [ACC_W-1:0] psum_new;
  logic             ovf_new;

  assign adv    = !vld_o_q | rdy_i;
  assign rdy_o  = adv;
  assign result = result_q;
  assign ovf_o  = ovf_q;
  assign vld_o  = vld_o_q;

  // Stage 3 arithmetic: widen so the add can never wrap, then range-check.
  always_comb begin
    base_w   = ctl2_q[0] ? '0 : {{(W-ACC_W){psum_q[ACC_W-1]}}, psum_q};
    nxt      = base_w + {{(W-SW){sum_q[SW-1]}}, sum_q};
    oor      = (nxt != {{(W-ACC_W){nxt[ACC_W-1]}}, nxt[ACC_W-1:0]});
    psum_new = nxt[ACC_W-1:0];
    if (sat_en && oor) begin
      psum_new = nxt[W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    ovf_new  = (ctl2_q[0] ? 1'b0 : ovf_grp_q) | oor;
  end

  // Next-state for all pipeline stages; everything holds while adv is low.
  always_comb begin
    for (int i = 0; i < LANES; i++) prod_d[i] = prod_q[i];
    v1_d      = v1_q;
    ctl1_d    = ctl1_q;
    sum_d     = sum_q;
    v2_d      = v2_q;
    ctl2_d    = ctl2_q;
    psum_d    = psum_q;
    ovf_grp_d = ovf_grp_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    vld_o_d   = vld_o_q;
    if (adv) begin
      for (int i = 0; i < LANES; i++) begin
        prod_d[i] = PW'($signed(neuron[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
      end
      v1_d   = vld_i;
      ctl1_d = ctl;
      sum_d  = '0;
      for (int i = 0; i < LANES; i++) begin
        sum_d = sum_d + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
      end
      v2_d   = v1_q;
      ctl2_d = ctl1_q;
      if (v2_q) begin
        psum_d    = psum_new;
        ovf_grp_d = ovf_new;
      end
    end
    if (adv && v2_q && ctl2_q[1]) begin
      result_d = psum_new;
      ovf_d    = ovf_new;
      vld_o_d  = 1'b1;
    end else if (rdy_i) begin
      vld_o_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset; reset drops in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      v1_q      <= 1'b0;
      ctl1_q    <= '0;
      sum_q     <= '0;
      v2_q      <= 1'b0;
      ctl2_q    <= '0;
      psum_q    <= '0;
      ovf_grp_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      vld_o_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      v1_q      <= v1_d;
      ctl1_q    <= ctl1_d;
      sum_q     <= sum_d;
      v2_q      <= v2_d;
      ctl2_q    <= ctl2_d;
      psum_q    <= psum_d;
      ovf_grp_q <= ovf_grp_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      vld_o_q   <= vld_o_d;
    end
  end

endmodule

// File: tb/tb_parallel_pe_pipe.sv
// Testbench for parallel_pe_pipe: directed groups with hand-computed sums,
// a stall scenario, mid-group reset and a random bubble/backpressure run
// checked against a behavioural integer model through an expected queue.
module tb_parallel_pe_pipe;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int ACC_W = 32;
  localparam int VW    = LANES * DW;

  logic             clk;
  logic             rst;
  logic [VW-1:0]    neuron;
  logic [VW-1:0]    weight;
  logic [1:0]       ctl;
  logic             vld_i;
  logic             rdy_o;
  logic             sat_en;
  logic [ACC_W-1:0] result;
  logic             ovf_o;
  logic             vld_o;
  logic             rdy_i;

  parallel_pe_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .sat_en (sat_en),
    .result (result),
    .ovf_o  (ovf_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [ACC_W:0] exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   out_cnt  = 0;
  int   last_cnt = 0;
  longint m_psum = 0;
  bit     m_ovf  = 0;
  bit   rand_rdy  = 0;
  bit   rdy_force = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Sole driver of rdy_i: fixed level or random backpressure.
  initial begin
    rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: pops one expected entry for every result transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && vld_o && rdy_i) begin
        out_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result_chk: unexpected result res=%h ovf=%b", result, ovf_o);
        end else begin
          logic [ACC_W:0] e;
          e = exp_q.pop_front();
          if ({ovf_o, result} !== e) begin
            failures++;
            $display("FAIL result_chk: got res=%h ovf=%b expected res=%h ovf=%b",
                     result, ovf_o, e[ACC_W-1:0], e[ACC_W]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic longint dot(input logic [VW-1:0] n, input logic [VW-1:0] w);
    longint acc;
    acc = 0;
    for (int i = 0; i < LANES; i++) begin
      acc += longint'($signed(n[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    end
    return acc;
  endfunction

  task automatic model_beat(input logic [VW-1:0] n, input logic [VW-1:0] w, input logic [1:0] c,
                            input bit hand, input logic [ACC_W-1:0] hres, input logic hovf);
    longint base, nx, stored;
    bit oor;
    base   = c[0] ? 0 : m_psum;
    nx     = base + dot(n, w);
    oor    = (nx > 64'sd2147483647) || (nx < -64'sd2147483648);
    if (oor && sat_en) stored = (nx > 0) ? 64'sd2147483647 : -64'sd2147483648;
    else               stored = longint'($signed(nx[31:0]));
    m_psum = stored;
    m_ovf  = (c[0] ? 1'b0 : m_ovf) | oor;
    if (c[1]) begin
      last_cnt++;
      if (hand) exp_q.push_back({hovf, hres});
      else      exp_q.push_back({m_ovf, stored[31:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [VW-1:0] n, input logic [VW-1:0] w, input logic [1:0] c,
                           input bit hand, input logic [ACC_W-1:0] hres, input logic hovf);
    int waits;
    neuron = n;
    weight = w;
    ctl    = c;
    vld_i  = 1'b1;
    waits  = 0;
    @(negedge clk);
    while (!rdy_o && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!rdy_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: rdy_o stuck at %b, required 1", rdy_o);
    end else begin
      model_beat(n, w, c, hand, hres, hovf);
    end
    @(posedge clk);
    #1;
    vld_i = 1'b0;
  endtask

  task automatic idle(input int k);
    vld_i = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waits;
    waits = 0;
    while (exp_q.size() != 0 && waits < 1000) begin
      @(posedge clk);
      waits++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  function automatic logic [VW-1:0] lane0(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[DW-1:0] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] all_lanes(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] rn, rw;
    logic [1:0]    rc;
    int            nb;

    rst = 1'b1; neuron = '0; weight = '0; ctl = '0; vld_i = 1'b0; sat_en = 1'b0;
    #12;
    check("reset_vld_o",  64'(vld_o),  64'd0);
    check("reset_rdy_o",  64'(rdy_o),  64'd1);
    check("reset_result", 64'(result), 64'd0);
    check("reset_ovf_o",  64'(ovf_o),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1: single beat, all lanes 1*2 -> 64; latency check
    send_beat(all_lanes(16'd1), all_lanes(16'd2), 2'b11, 1, 32'd64, 1'b0);
    @(negedge clk); check("lat_edge1_vld_o", 64'(vld_o), 64'd0);
    @(negedge clk); check("lat_edge2_vld_o", 64'(vld_o), 64'd0);
    @(negedge clk); check("lat_edge3_vld_o", 64'(vld_o), 64'd1);
    drain();

    // 2: four-beat group, lane0 3*-5 each -> -60; then restart from 0; then carry-on
    send_beat(lane0(16'd3), lane0(-16'sd5), 2'b01, 1, '0, 1'b0);
    send_beat(lane0(16'd3), lane0(-16'sd5), 2'b00, 1, '0, 1'b0);
    send_beat(lane0(16'd3), lane0(-16'sd5), 2'b00, 1, '0, 1'b0);
    send_beat(lane0(16'd3), lane0(-16'sd5), 2'b10, 1, 32'hFFFF_FFC4, 1'b0);
    send_beat(lane0(16'd1), lane0(16'd7),   2'b01, 1, '0, 1'b0);
    send_beat(lane0(16'd1), lane0(16'd7),   2'b10, 1, 32'd14, 1'b0);
    send_beat(lane0(16'd1), lane0(16'd1),   2'b10, 1, 32'd15, 1'b0);
    drain();

    // 3: 32 * (-32768)^2 = 2^35, saturated then wrapped
    sat_en = 1'b1;
    send_beat(all_lanes(16'h8000), all_lanes(16'h8000), 2'b11, 1, 32'h7FFF_FFFF, 1'b1);
    drain();
    sat_en = 1'b0;
    send_beat(all_lanes(16'h8000), all_lanes(16'h8000), 2'b11, 1, 32'h0000_0000, 1'b1);
    drain();

    // 4: stall with vld_o held and beats in flight
    rdy_force = 1'b0;
    idle(2);
    send_beat(lane0(16'd1), lane0(16'd10), 2'b11, 1, 32'd10, 1'b0);
    send_beat(lane0(16'd2), lane0(16'd10), 2'b11, 1, 32'd20, 1'b0);
    send_beat(lane0(16'd3), lane0(16'd10), 2'b11, 1, 32'd30, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rdy_o",  64'(rdy_o),  64'd0);
      check("stall_vld_o",  64'(vld_o),  64'd1);
      check("stall_result", 64'(result), 64'd10);
    end
    rdy_force = 1'b1;
    drain();

    // 5: random groups with bubbles and backpressure
    rand_rdy = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      if (g == 500) begin
        drain();
        sat_en = 1'b1;
        idle(2);
      end
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < LANES; i++) begin
          rn[i*DW +: DW] = DW'($urandom);
          rw[i*DW +: DW] = DW'($urandom);
        end
        rc[0] = (b == 0) && ($urandom_range(0, 7) != 0);
        rc[1] = (b == nb - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_beat(rn, rw, rc, 0, '0, 1'b0);
      end
    end
    drain();
    rand_rdy = 1'b0;
    sat_en = 1'b0;
    idle(2);

    // 6: reset with two beats in flight
    send_beat(lane0(16'd5), lane0(16'd5), 2'b01, 1, '0, 1'b0);
    send_beat(lane0(16'd5), lane0(16'd5), 2'b00, 1, '0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_vld_o", 64'(vld_o), 64'd0);
    check("midrst_rdy_o", 64'(rdy_o), 64'd1);
    m_psum = 0;
    m_ovf  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_beat(lane0(16'd2), lane0(16'd3), 2'b10, 1, 32'd6, 1'b0);
    send_beat(lane0(16'd1), lane0(16'd1), 2'b11, 1, 32'd1, 1'b0);
    drain();

    check("result_count", 64'(out_cnt), 64'(last_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
